// File: rtl/fp2_ptwise_sq_ctrl.sv
// Purpose: issue/collect controller around a fixed-latency, non-stallable Fp2 pointwise-square pipeline.
// Latency: a bundle accepted at edge t is captured into the result FIFO at edge t+LAT, visible after it.
// Backpressure: credit based; s_ready is low once in-pipeline plus buffered bundles reach DEPTH, never on m_ready.
module fp2_ptwise_sq_ctrl #(
  parameter int W     = 2040,
  parameter int LAT   = 20,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  input  logic [W-1:0] s_data,
  output logic         s_ready,
  output logic [W-1:0] u_data,
  output logic         u_issue,
  input  logic [W-1:0] u_res,
  output logic         m_valid,
  output logic [W-1:0] m_data,
  input  logic         m_ready,
  output logic         idle,
  output logic [6:0]   inflight,
  output logic         ovf
);

  // FIFO pointer width, occupancy width, and a sum width wide enough for inflight+count
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = ((CW > 7) ? CW : 7) + 1;

  // token shift register: one bit per pipeline stage, set where a bundle is in flight
  logic [LAT-1:0] r_tok;
  logic [6:0]     r_inflight;
  logic [CW-1:0]  r_count;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [W-1:0]   r_u_data;
  logic           r_u_issue;
  logic           r_ovf;
  logic [W-1:0]   r_mem [DEPTH];

  logic [SW-1:0]  w_sum;
  logic           w_ready;
  logic           w_issue;
  logic           w_push;
  logic           w_pop;
  logic           w_full;
  logic           w_wr;
  logic           w_drop;

  // credits are every slot not already claimed by the pipeline or the FIFO
  assign w_sum   = SW'(r_inflight) + SW'(r_count);
  assign w_ready = (w_sum < SW'(DEPTH));
  assign w_issue = s_valid && w_ready;

  // the result for the oldest token is on u_res on the edge the token leaves the shift register
  assign w_push  = r_tok[LAT-1];
  assign w_pop   = (r_count != '0) && m_ready;
  assign w_full  = (r_count == CW'(DEPTH));

  // a full FIFO can still take a push on an edge where it also pops (the head slot frees up)
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  assign s_ready  = w_ready;
  assign u_data   = r_u_data;
  assign u_issue  = r_u_issue;
  assign m_valid  = (r_count != '0);
  assign m_data   = m_valid ? r_mem[r_rd_ptr] : '0;
  assign idle     = (r_inflight == 7'd0) && (r_count == '0);
  assign inflight = r_inflight;
  assign ovf      = r_ovf;

  // operand register toward the unit, plus the one-cycle load marker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_u_data  <= '0;
      r_u_issue <= 1'b0;
    end else begin
      if (w_issue) begin
        r_u_data <= s_data;
      end
      r_u_issue <= w_issue;
    end
  end

  // token pipeline mirrors the unit's fixed latency; clearing it forgets stale unit outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tok <= '0;
    end else begin
      r_tok <= {r_tok[LAT-2:0], w_issue};
    end
  end

  // number of bundles between issue and capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= 7'd0;
    end else if (w_issue && !w_push) begin
      r_inflight <= r_inflight + 7'd1;
    end else if (!w_issue && w_push) begin
      r_inflight <= r_inflight - 7'd1;
    end
  end

  // FIFO pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // FIFO occupancy: accepted pushes in, pops out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_wr && !w_pop) begin
      r_count <= r_count + CW'(1);
    end else if (!w_wr && w_pop) begin
      r_count <= r_count - CW'(1);
    end
  end

  // sticky error: a result arrived with nowhere to go and was thrown away
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  // result storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= u_res;
    end
  end

endmodule
